// File: rtl/encoder_pkg.sv
// Shared types and helpers for the iterative priority encoder.
package encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Index width for a vector of w bits; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 32'd1) ? 32'($clog2(w)) : 32'd1;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: highest (dir=1) or lowest (dir=0) set bit of vec.
module prio_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             dir,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             single
);

    // Later matches overwrite earlier ones, so the scan order picks the winner.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (dir) begin
                if (vec[i]) idx = IDXW'(i);
            end else begin
                if (vec[WIDTH-1-i]) idx = IDXW'(WIDTH-1-i);
            end
        end
    end

    assign any    = |vec;
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_encoder_iter.sv
// Enumerates the set bits of an accepted vector, one index per output handshake.
module priority_encoder_iter
    import encoder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             zero_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             dir_q, dir_d;
    logic             zero_err_q, zero_err_d;
    logic             out_valid_q, out_valid_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [IDXW-1:0]  enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic             emit_d;

    // Encoder looks at the next-cycle pending set so the index outputs can be registered.
    prio_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_prio_enc (
        .vec    (pending_d),
        .dir    (dir_d),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        dir_d      = dir_q;
        zero_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (|in_vec) begin
                        pending_d = in_vec;
                        dir_d     = msb_first;
                        state_d   = EMIT;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << out_idx_q);
                    if (out_last_q) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        emit_d      = (state_d == EMIT);
        out_valid_d = emit_d && enc_any;
        out_idx_d   = emit_d ? enc_idx : '0;
        out_last_d  = emit_d && enc_single;
        in_ready_d  = (state_d == IDLE);
        busy_d      = emit_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            dir_q       <= 1'b0;
            zero_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            dir_q       <= dir_d;
            zero_err_q  <= zero_err_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign zero_err  = zero_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_priority_encoder_iter.sv
// Directed scoreboard bench for priority_encoder_iter at WIDTH=8 and WIDTH=32.
module tb_priority_encoder_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid8, in_ready8, msb8, out_valid8, out_ready8, out_last8, zero_err8, busy8;
    logic [7:0] in_vec8;
    logic [2:0] out_idx8;

    logic        in_valid32, in_ready32, msb32, out_valid32, out_ready32, out_last32, zero_err32, busy32;
    logic [31:0] in_vec32;
    logic [4:0]  out_idx32;

    priority_encoder_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_vec(in_vec8), .msb_first(msb8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_idx(out_idx8), .out_last(out_last8), .zero_err(zero_err8), .busy(busy8)
    );

    priority_encoder_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_vec(in_vec32), .msb_first(msb32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_idx(out_idx32), .out_last(out_last32), .zero_err(zero_err32), .busy(busy32)
    );

    typedef struct packed {
        logic [5:0] idx;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: list the set bits in scan order, flag the final one.
    task automatic push_exp(input logic [63:0] vec, input logic dir, input int w);
        int   n;
        int   seen;
        int   i;
        exp_t e;
        n    = 0;
        seen = 0;
        for (int j = 0; j < w; j++) if (vec[j]) n++;
        for (int j = 0; j < w; j++) begin
            i = dir ? (w - 1 - j) : j;
            if (vec[i]) begin
                seen++;
                e.idx  = 6'(i);
                e.last = (seen == n);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send8(input logic [7:0] v, input logic d);
        check("in_ready8_pre", 64'(in_ready8), 64'd1);
        in_valid8 = 1'b1;
        in_vec8   = v;
        msb8      = d;
        push_exp(64'(v), d, 8);
        tick();
        in_valid8 = 1'b0;
        in_vec8   = 8'($urandom);
        msb8      = 1'($urandom);
    endtask

    // Pop and compare one index per cycle with out_ready high; garbage is offered on the input meanwhile.
    task automatic drain8(input int start_cyc, input int total_cyc);
        int   cyc;
        exp_t e;
        cyc = start_cyc;
        out_ready8 = 1'b1;
        while (exp_q.size() != 0 && cyc < 40) begin
            e = exp_q.pop_front();
            check("out_valid8", 64'(out_valid8), 64'd1);
            check("out_idx8", 64'(out_idx8), 64'(e.idx));
            check("out_last8", 64'(out_last8), 64'(e.last));
            check("busy8", 64'(busy8), 64'd1);
            check("in_ready8_busy", 64'(in_ready8), 64'd0);
            in_valid8 = 1'b1;
            in_vec8   = 8'($urandom);
            msb8      = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid8 = 1'b0;
        check("sb_empty8", 64'(exp_q.size()), 64'd0);
        check("in_ready8_after", 64'(in_ready8), 64'd1);
        check("out_valid8_after", 64'(out_valid8), 64'd0);
        check("out_idx8_idle", 64'(out_idx8), 64'd0);
        check("latency8", 64'(cyc), 64'(total_cyc));
    endtask

    initial begin
        exp_t e;
        rst_n       = 1'b0;
        in_valid8   = 1'b0; in_vec8  = '0; msb8  = 1'b0; out_ready8  = 1'b1;
        in_valid32  = 1'b0; in_vec32 = '0; msb32 = 1'b0; out_ready32 = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready8), 64'd1);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_out_valid", 64'(out_valid8), 64'd0);
        check("rst_out_idx", 64'(out_idx8), 64'd0);
        check("rst_out_last", 64'(out_last8), 64'd0);
        check("rst_zero_err", 64'(zero_err8), 64'd0);
        tick();

        // Release and accept on the very next edge; lsb-first then msb-first of 1010_0101
        rst_n = 1'b1;
        send8(8'b1010_0101, 1'b0);
        drain8(1, 5);
        send8(8'b1010_0101, 1'b1);
        drain8(1, 5);

        // Boundary bits and a full vector
        send8(8'b1000_0000, 1'b0);
        drain8(1, 2);
        send8(8'b0000_0001, 1'b1);
        drain8(1, 2);
        send8(8'b1111_1111, 1'b1);
        drain8(1, 9);

        // All-zero vector: one-cycle zero_err, no output
        in_valid8 = 1'b1;
        in_vec8   = 8'h00;
        msb8      = 1'b0;
        tick();
        in_valid8 = 1'b0;
        check("zero_err_hi", 64'(zero_err8), 64'd1);
        check("zero_out_valid", 64'(out_valid8), 64'd0);
        check("zero_in_ready", 64'(in_ready8), 64'd1);
        check("zero_busy", 64'(busy8), 64'd0);
        tick();
        check("zero_err_lo", 64'(zero_err8), 64'd0);
        check("zero_out_valid2", 64'(out_valid8), 64'd0);

        // Back-pressure: index 0 must hold while out_ready is low
        out_ready8 = 1'b0;
        send8(8'b1000_0001, 1'b0);
        for (int s = 0; s < 2; s++) begin
            check("stall_valid", 64'(out_valid8), 64'd1);
            check("stall_idx", 64'(out_idx8), 64'(exp_q[0].idx));
            check("stall_last", 64'(out_last8), 64'(exp_q[0].last));
            tick();
        end
        drain8(3, 5);

        // Reset in the middle of enumerating 1111_0000
        send8(8'b1111_0000, 1'b0);
        e = exp_q.pop_front();
        check("prerst_idx", 64'(out_idx8), 64'(e.idx));
        check("prerst_valid", 64'(out_valid8), 64'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 64'(out_valid8), 64'd0);
        check("midrst_out_idx", 64'(out_idx8), 64'd0);
        check("midrst_out_last", 64'(out_last8), 64'd0);
        check("midrst_in_ready", 64'(in_ready8), 64'd1);
        check("midrst_busy", 64'(busy8), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("postrst_out_valid", 64'(out_valid8), 64'd0);
            check("postrst_busy", 64'(busy8), 64'd0);
        end
        send8(8'b0010_0100, 1'b1);
        drain8(1, 3);

        // WIDTH=32 one-hot sweep in both directions
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 32; k++) begin
                check("w32_in_ready", 64'(in_ready32), 64'd1);
                in_valid32 = 1'b1;
                in_vec32   = 32'd1 << k;
                msb32      = 1'(d);
                push_exp(64'(in_vec32), msb32, 32);
                tick();
                in_valid32 = 1'b0;
                e = exp_q.pop_front();
                check("w32_valid", 64'(out_valid32), 64'd1);
                check("w32_idx", 64'(out_idx32), 64'(e.idx));
                check("w32_last", 64'(out_last32), 64'(e.last));
                tick();
                check("w32_single", 64'(out_valid32), 64'd0);
                check("w32_idle", 64'(in_ready32), 64'd1);
            end
        end
        check("sb_empty32", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/priority_encoder_iter.md
PRIORITY_ENCODER_ITER -- requirements
Module: priority_encoder_iter

Interface
REQ-001 Parameter WIDTH, default 8: input vector width; SHALL be a power of two, 4..64.
REQ-002 Parameter IDXW, default $clog2(WIDTH): index width; SHALL be derived, never overridden.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_vec/msb_first valid this cycle.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 in_vec  input  WIDTH  one-hot or multi-hot request vector.
REQ-008 msb_first  input  1  scan direction: 1 = highest set bit first, 0 = lowest first; sampled at accept.
REQ-009 out_valid  output  1  out_idx/out_last valid.
REQ-010 out_ready  input  1  consumer accepts current index.
REQ-011 out_idx  output  IDXW  bit position of the current set bit.
REQ-012 out_last  output  1  current index is the final set bit of this vector.
REQ-013 zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.
REQ-014 busy  output  1  a vector is being enumerated.

Function
REQ-015 Two-state FSM: IDLE, EMIT.
REQ-016 in_ready SHALL be 1 exactly when state == IDLE; accept = in_valid && in_ready.
REQ-017 On accept with in_vec != 0: latch in_vec into pending[WIDTH-1:0]; latch msb_first into dir_q; go to EMIT next cycle.
REQ-018 On accept with in_vec == 0: remain IDLE; assert zero_err for exactly the following cycle; produce no output.
REQ-019 In EMIT, out_valid SHALL be 1; out_idx SHALL equal the highest (dir_q=1) or lowest (dir_q=0) set bit of pending.
REQ-020 out_last SHALL be 1 when pending has exactly one bit set.
REQ-021 Output handshake (out_valid && out_ready) SHALL clear bit out_idx of pending at that edge.
REQ-022 Handshake with out_last=1 SHALL move to IDLE; in_ready SHALL be 1 the next cycle (no same-cycle re-accept).
REQ-023 While out_valid && !out_ready, out_idx, out_last and pending SHALL hold stable.
REQ-024 Latency: first index valid 1 cycle after accept; thereafter one index per cycle under continuous out_ready; a vector with K set bits SHALL occupy K+1 cycles from accept to in_ready.
REQ-025 busy SHALL equal (state == EMIT); in IDLE, out_valid=0, out_last=0, and out_idx=0.
REQ-026 in_vec/msb_first changes while !in_ready SHALL have no effect.
REQ-027 Bit WIDTH-1 and bit 0 SHALL be handled identically to interior bits (no wrap, no off-by-one at either end).

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, pending=0, dir_q=0, zero_err=0, out_valid=0, out_last=0, out_idx=0, in_ready=1, busy=0.
REQ-029 Reset mid-EMIT SHALL discard the partially enumerated vector; no index SHALL be emitted after release until a new accept.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package encoder_pkg SHALL hold the state enum (IDLE, EMIT) and a clog2-based index-width helper.
REQ-032 Combinational sub-module prio_enc SHALL be instantiated (params WIDTH, IDXW; ports vec, dir, idx, any, single); the FSM, pending register and handshake remain in priority_encoder_iter.
REQ-033 No latches; all registers SHALL share one always block per clock/reset pair.

Verification
REQ-034 WIDTH=8, msb_first=0, in_vec=8'b1010_0101, out_ready=1 -> out_idx 0,2,5,7 on consecutive cycles; out_last only with 7; in_ready high the cycle after.
REQ-035 Same vector, msb_first=1 -> out_idx 7,5,2,0; out_last with 0.
REQ-036 in_vec=8'b0000_0000 accepted -> zero_err high exactly one cycle; out_valid stays 0; in_ready stays 1.
REQ-037 in_vec=8'b1000_0001, out_ready low 3 cycles then high -> out_idx=0 held stable for 3 cycles, then 7 with out_last.
REQ-038 Assert rst_n=0 after the first index of 8'b1111_0000 -> all outputs reset immediately; no further out_valid until the next accept.
REQ-039 WIDTH=32, one-hot sweep 1<<k for k=0..31, both directions -> out_idx=k with out_last=1, single output per vector.
